systolic_feed_ctrl: RTL
=======================

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ROW, default 4, number of weight rows and width of readw/writew.
REQ-003 SHALL have parameter COL, default 4, number of input columns and width of readn/writen.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a load/feed job.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid.
REQ-008 SHALL have port in_data, input, WIDTH, source word.
REQ-009 SHALL have port in_ready, output, 1, controller accepts in_data.
REQ-010 SHALL have port data_out, output, WIDTH, word driven to the datapath data_in.
REQ-011 SHALL have port writew, output, ROW, one-hot weight-row write strobe.
REQ-012 SHALL have port writen, output, COL, one-hot input-column write strobe.
REQ-013 SHALL have port cs, output, 1, datapath compute select.
REQ-014 SHALL have port readw, output, ROW, skewed weight read mask.
REQ-015 SHALL have port readn, output, COL, skewed input read mask.
REQ-016 SHALL have port dp_done, input, 1, datapath done.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port finished, output, 1, one-cycle job-complete pulse.

Function
REQ-019 SHALL implement states IDLE, LOAD_W, GAP, LOAD_N, CS_SETUP, FEED, WAIT_DONE, FIN.
REQ-020 SHALL go IDLE->LOAD_W on start=1; start outside IDLE is ignored.
REQ-021 SHALL drive in_ready=1 only in LOAD_W and LOAD_N; a word is accepted when in_valid&in_ready at a rising edge.
REQ-022 SHALL in LOAD_W accept ROW*COL words: words 0..COL-1 go to row 0, the next COL to row 1, and so on.
REQ-023 SHALL in LOAD_N accept COL*ROW words: words 0..ROW-1 go to column 0, the next ROW to column 1, and so on.
REQ-024 SHALL, in the cycle after each accepted word, drive data_out=word and exactly one writew/writen bit (the current row/column) for one cycle; otherwise strobes are 0.
REQ-025 SHALL hold data_out at its last value when no strobe is active.
REQ-026 SHALL insert idle cycles in load states without a valid word; no strobe and counters are held.
REQ-027 SHALL go from LOAD_W after the last weight strobe to GAP for exactly one cycle with all strobes 0, then to LOAD_N.
REQ-028 SHALL go from LOAD_N after the last input strobe to CS_SETUP, where cs=1 and masks are 0 for one cycle.
REQ-029 SHALL run FEED for ROW+COL-1 cycles; in FEED cycle k (k=1..), readw has its low min(k,ROW) bits set and readn has its low min(k,COL) bits set.
REQ-030 SHALL enter WAIT_DONE with readw=readn=0 and cs held at 1.
REQ-031 SHALL sample dp_done only in WAIT_DONE; when dp_done=1, the next state is FIN.
REQ-032 SHALL in FIN drive cs=0 and finished=1 for one cycle, then return to IDLE.
REQ-033 SHALL hold cs=1 continuously from CS_SETUP through WAIT_DONE and 0 elsewhere.
REQ-034 SHALL ignore in_valid and in_data outside load states.

Reset
REQ-035 SHALL, on rst=1 at a clock edge in any state including mid-load or mid-feed, go to IDLE and clear the counters.
REQ-036 SHALL, when rst=1, set data_out=0, writew=0, writen=0, readw=0, readn=0, cs=0, in_ready=0, busy=0 and finished=0.
REQ-037 SHALL let rst take priority over start and dp_done in the same cycle.

Verification
REQ-038 SHALL test a full job: start, then words 1..16 continuous, then 1,5,9,13,2,...,16 continuous.
- writew steps 0001x4, 0010x4, 0100x4, 1000x4 with data_out 1..16.
- One GAP cycle follows.
- writen steps 0001..1000 with data_out 1,5,9,13,...
- cs rises; masks 0001, 0011, 0111, 1111, 1111, 1111, 1111, then 0.
- dp_done after 5 cycles gives finished one cycle later and cs=0.
REQ-039 SHALL test in_valid toggling every other cycle in LOAD_W: strobes appear only after accepted words, totalling 16, and the row order is unchanged.
REQ-040 SHALL test rst=1 during FEED cycle 3: the next cycle has all outputs 0 and busy=0; a new start runs a full job correctly.
REQ-041 SHALL test dp_done=1 during LOAD_N and FEED: it is ignored and the FSM still waits in WAIT_DONE.
REQ-042 SHALL test start=1 while busy: no restart, and word counts are unaffected.
REQ-043 SHALL test ROW=2, COL=3: FEED lasts 4 cycles; readw is 01,11,11,11 and readn is 001,011,111,111.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// Purpose : sequences weight/input loading and skewed read-mask feeding for a systolic array datapath.
// Latency : each accepted word is presented on data_out with its write strobe one cycle after acceptance.
// Backpress: in_ready is high only while a load state still needs words; idle source cycles just stall.
//
// Ports:
//   clk, rst                 - single clock, synchronous active-high reset
//   start                    - one-cycle job request (honoured only in IDLE)
//   in_valid/in_data/in_ready- source word handshake
//   data_out, writew, writen - registered word and one-hot row/column write strobes
//   cs, readw, readn         - compute select and skewed read masks
//   dp_done                  - datapath completion, looked at only while waiting for it
//   busy, finished           - activity flag and one-cycle completion pulse
module systolic_feed_ctrl #(
  parameter int WIDTH = 32,
  parameter int ROW   = 4,
  parameter int COL   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [ROW-1:0]   writew,
  output logic [COL-1:0]   writen,
  output logic             cs,
  output logic [ROW-1:0]   readw,
  output logic [COL-1:0]   readn,
  input  logic             dp_done,
  output logic             busy,
  output logic             finished
);

  localparam int FEED_LEN = ROW + COL - 1;
  localparam int CW       = $clog2(ROW + COL) + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_W, GAP, LOAD_N, CS_SETUP, FEED, WAIT_DONE, FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    inner_q, inner_d;   // word position inside current row/column
  logic [CW-1:0]    outer_q, outer_d;   // current row (LOAD_W) or column (LOAD_N)
  logic [CW-1:0]    feed_q, feed_d;     // FEED cycle number, 1-based
  logic             load_done_q, load_done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ROW-1:0]   writew_q, writew_d;
  logic [COL-1:0]   writen_q, writen_d;

  logic          accept;
  logic [CW-1:0] inner_last;
  logic [CW-1:0] outer_last;

  // Once the final word of a load phase is taken, load_done_q holds the FSM in
  // that state for the strobe cycle of the last word while refusing new words.
  assign in_ready   = ((state_q == LOAD_W) || (state_q == LOAD_N)) && !load_done_q;
  assign accept     = in_ready && in_valid;
  assign inner_last = (state_q == LOAD_W) ? CW'(COL - 1) : CW'(ROW - 1);
  assign outer_last = (state_q == LOAD_W) ? CW'(ROW - 1) : CW'(COL - 1);

  always_comb begin
    state_d     = state_q;
    inner_d     = inner_q;
    outer_d     = outer_q;
    feed_d      = feed_q;
    load_done_d = load_done_q;
    data_d      = data_q;
    writew_d    = '0;
    writen_d    = '0;

    // Shared word-position advance for both load phases.
    if (accept) begin
      data_d = in_data;
      if (inner_q == inner_last) begin
        inner_d = '0;
        if (outer_q == outer_last) begin
          outer_d     = '0;
          load_done_d = 1'b1;
        end else begin
          outer_d = outer_q + 1'b1;
        end
      end else begin
        inner_d = inner_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD_W;
          inner_d     = '0;
          outer_d     = '0;
          feed_d      = '0;
          load_done_d = 1'b0;
        end
      end
      LOAD_W: begin
        if (load_done_q) begin
          state_d     = GAP;
          load_done_d = 1'b0;
        end else if (accept) begin
          for (int i = 0; i < ROW; i++) writew_d[i] = (outer_q == CW'(i));
        end
      end
      GAP: state_d = LOAD_N;
      LOAD_N: begin
        if (load_done_q) begin
          state_d     = CS_SETUP;
          load_done_d = 1'b0;
        end else if (accept) begin
          for (int i = 0; i < COL; i++) writen_d[i] = (outer_q == CW'(i));
        end
      end
      CS_SETUP: begin
        state_d = FEED;
        feed_d  = CW'(1);
      end
      FEED: begin
        if (feed_q == CW'(FEED_LEN)) begin
          state_d = WAIT_DONE;
          feed_d  = '0;
        end else begin
          feed_d = feed_q + 1'b1;
        end
      end
      WAIT_DONE: if (dp_done) state_d = FIN;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      inner_q     <= '0;
      outer_q     <= '0;
      feed_q      <= '0;
      load_done_q <= 1'b0;
      data_q      <= '0;
      writew_q    <= '0;
      writen_q    <= '0;
    end else begin
      state_q     <= state_d;
      inner_q     <= inner_d;
      outer_q     <= outer_d;
      feed_q      <= feed_d;
      load_done_q <= load_done_d;
      data_q      <= data_d;
      writew_q    <= writew_d;
      writen_q    <= writen_d;
    end
  end

  assign data_out = data_q;
  assign writew   = writew_q;
  assign writen   = writen_q;
  assign cs       = (state_q == CS_SETUP) || (state_q == FEED) || (state_q == WAIT_DONE);
  assign busy     = (state_q != IDLE);
  assign finished = (state_q == FIN);

  // Mask bit i lights once feed cycle k exceeds i, which yields min(k, ROW/COL) low bits.
  always_comb begin
    readw = '0;
    readn = '0;
    for (int i = 0; i < ROW; i++) readw[i] = (state_q == FEED) && (CW'(i) < feed_q);
    for (int i = 0; i < COL; i++) readn[i] = (state_q == FEED) && (CW'(i) < feed_q);
  end

endmodule
